uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between three message sources.
// Optional forced release of a stalled owner is compiled in with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int TIMEOUT_CYC = 50_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [23:0] req_data,
   input  logic [2:0]  req_last,
   output logic [2:0]  ack,
   output logic [2:0]  grant,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic        timeout_err
);

   // Handshakes: a requester holds req[i] with its byte on req_data[i] until ack[i]
   // pulses; the byte is captured in LOAD and ack follows one cycle later together
   // with tx_start. The UART raises tx_busy after tx_start and drops it when done.
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_WAIT_HI = 3'd2;
   localparam logic [2:0] S_WAIT_LO = 3'd3;
   localparam logic [2:0] S_HOLD    = 3'd4;

   if (TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
   end

   logic [2:0] state;
   logic [1:0] owner;
   logic [1:0] last_owner;
   logic       is_last;
   logic       win_valid;
   logic [1:0] win_idx;
   logic [1:0] cand;
   logic       tmo_hit;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search starts just after the previous owner so every requester gets a turn.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = 2'd0;
      cand      = next_idx(last_owner);
      for (int k = 0; k < 3; k++) begin
         if (!win_valid && req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
         cand = next_idx(cand);
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] tmo_cnt;
   logic          tmo_err_q;

   assign tmo_hit     = ((state == S_WAIT_HI) || (state == S_HOLD)) && (tmo_cnt == TMO_LAST);
   assign timeout_err = tmo_err_q;

   // Cleared on the transitions into WAIT_HI (from LOAD) and HOLD (from WAIT_LO).
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt   <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_err_q <= tmo_hit;
         if ((state == S_LOAD) || ((state == S_WAIT_LO) && !tx_busy)) begin
            tmo_cnt <= '0;
         end else if ((state == S_WAIT_HI) || (state == S_HOLD)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         owner      <= 2'd0;
         last_owner <= 2'd2;
         is_last    <= 1'b0;
         grant      <= 3'b000;
         ack        <= 3'b000;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
      end else begin
         tx_start <= 1'b0;
         ack      <= 3'b000;
         case (state)
            S_IDLE: begin
               if (win_valid) begin
                  owner <= win_idx;
                  grant <= 3'b001 << win_idx;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx_data  <= req_data[{owner, 3'b000} +: 8];
               tx_start <= 1'b1;
               ack      <= 3'b001 << owner;
               is_last  <= req_last[owner];
               state    <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (tmo_hit) begin
                  last_owner <= owner;
                  grant      <= 3'b000;
                  state      <= S_IDLE;
               end else if (tx_busy) begin
                  state <= S_WAIT_LO;
               end
            end
            S_WAIT_LO: begin
               if (!tx_busy) begin
                  if (is_last) begin
                     last_owner <= owner;
                     grant      <= 3'b000;
                     state      <= S_IDLE;
                  end else begin
                     state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               // Packet lock: only the current owner may continue its message.
               if (tmo_hit) begin
                  last_owner <= owner;
                  grant      <= 3'b000;
                  state      <= S_IDLE;
               end else if (req[owner]) begin
                  state <= S_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, UART busy model, scoreboard of expected bytes.
// Define UART_ARB_TIMEOUT_EN for both bench and RTL to exercise the forced-release path.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [23:0] req_data;
   logic [2:0]  req_last;
   logic [2:0]  ack;
   logic [2:0]  grant;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        timeout_err;

   uart_tx_arbiter #(.TIMEOUT_CYC(100)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .req_last    (req_last),
      .ack         (ack),
      .grant       (grant),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   // Scoreboard entry: {grant one-hot, byte}; requester queue entry: {last, byte}
   logic [10:0] exp_q[$];
   logic [8:0]  q0[$];
   logic [8:0]  q1[$];
   logic [8:0]  q2[$];

   int   busy_cnt = 0;
   int   busy_fixed = 0;
   int   n_starts = 0;
   int   last_start_cyc = 0;
   int   last_fall_cyc = 0;
   int   tmo_seen = 0;
   int   tmo_cyc = 0;
   int   rise_cyc[3];
   logic prev_start = 1'b0;
   logic [2:0] req_prev = 3'b000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Monitor, UART model and requester drivers, all sampled/driven on the falling edge.
   initial begin
      logic [10:0] e;
      req = 3'b000; req_data = 24'h0; req_last = 3'b000; tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (tx_start) begin
            n_starts++;
            last_start_cyc = cyc;
            check("start_pulse_width", {31'b0, prev_start}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_start", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", {24'b0, tx_data}, {24'b0, e[7:0]});
               check("grant", {29'b0, grant}, {29'b0, e[10:8]});
               check("ack", {29'b0, ack}, {29'b0, e[10:8]});
            end
         end
         prev_start = tx_start;
         if (timeout_err) begin
            tmo_seen++;
            tmo_cyc = cyc;
         end
         if (ack[0] && q0.size() != 0) void'(q0.pop_front());
         if (ack[1] && q1.size() != 0) void'(q1.pop_front());
         if (ack[2] && q2.size() != 0) void'(q2.pop_front());
         if (tx_busy) begin
            busy_cnt--;
            if (busy_cnt <= 0) begin
               tx_busy = 1'b0;
               last_fall_cyc = cyc;
            end
         end
         if (tx_start) begin
            tx_busy  = 1'b1;
            busy_cnt = (busy_fixed != 0) ? busy_fixed : int'($urandom_range(20, 3));
         end
         req = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
         req_data[7:0]   = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
         req_data[15:8]  = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
         req_data[23:16] = (q2.size() != 0) ? q2[0][7:0] : 8'h00;
         req_last[0] = (q0.size() != 0) ? q0[0][8] : 1'b0;
         req_last[1] = (q1.size() != 0) ? q1[0][8] : 1'b0;
         req_last[2] = (q2.size() != 0) ? q2[0][8] : 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (req[i] && !req_prev[i]) rise_cyc[i] = cyc;
         end
         req_prev = req;
      end
   end

   task automatic wait_idle(input string tag, input int budget);
      int  k;
      bit  done;
      k = 0;
      done = 1'b0;
      while (!done && k < budget) begin
         tick();
         k++;
         done = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) &&
                (exp_q.size() == 0) && (grant == 3'b000) && !tx_busy;
      end
      check({tag, "_done"}, {31'b0, done}, 32'd1);
   endtask

   task automatic wait_grant(input string tag, input logic [2:0] g, input int budget);
      int k;
      k = 0;
      while (grant != g && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_grant"}, {29'b0, grant}, {29'b0, g});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      int starts_before;
      int bad;
      rst = 1'b0;
      tick();
      tick();
      check("rst_grant", {29'b0, grant}, 32'd0);
      check("rst_ack", {29'b0, ack}, 32'd0);
      check("rst_tx_start", {31'b0, tx_start}, 32'd0);
      check("rst_tx_data", {24'b0, tx_data}, 32'd0);
      check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
      rst = 1'b1;
      tick();

      // Single byte from requester 1, long UART busy time
      busy_fixed = 1000;
      q1.push_back({1'b1, 8'h41});
      exp_q.push_back({3'b010, 8'h41});
      wait_idle("single", 1300);
      check("latency", last_start_cyc - rise_cyc[1], 32'd2);
      check("single_grant_free", {29'b0, grant}, 32'd0);
      check("tx_data_hold", {24'b0, tx_data}, 32'h41);
      busy_fixed = 0;

      // All three requesting from reset: order 0, 1, 2, 0
      do_reset();
      q0.push_back({1'b1, 8'h30});
      q0.push_back({1'b1, 8'h30});
      q1.push_back({1'b1, 8'h31});
      q2.push_back({1'b1, 8'h32});
      exp_q.push_back({3'b001, 8'h30});
      exp_q.push_back({3'b010, 8'h31});
      exp_q.push_back({3'b100, 8'h32});
      exp_q.push_back({3'b001, 8'h30});
      wait_idle("rr_from_reset", 400);

      // Last owner is now 0: simultaneous requests go 1, 2, 0
      q0.push_back({1'b1, 8'h50});
      q1.push_back({1'b1, 8'h51});
      q2.push_back({1'b1, 8'h52});
      exp_q.push_back({3'b010, 8'h51});
      exp_q.push_back({3'b100, 8'h52});
      exp_q.push_back({3'b001, 8'h50});
      wait_idle("rr_after_0", 400);

      // Multi-byte packet from requester 2 is not interleaved with requester 0
      q2.push_back({1'b0, 8'h48});
      q2.push_back({1'b0, 8'h32});
      q2.push_back({1'b0, 8'h35});
      q2.push_back({1'b1, 8'h0A});
      exp_q.push_back({3'b100, 8'h48});
      exp_q.push_back({3'b100, 8'h32});
      exp_q.push_back({3'b100, 8'h35});
      exp_q.push_back({3'b100, 8'h0A});
      exp_q.push_back({3'b001, 8'h5A});
      wait_grant("lock", 3'b100, 10);
      q0.push_back({1'b1, 8'h5A});
      wait_idle("lock", 600);

      // Reset during WAIT_LO drops the message
      busy_fixed = 10;
      q1.push_back({1'b0, 8'h61});
      q1.push_back({1'b0, 8'h62});
      q1.push_back({1'b1, 8'h63});
      exp_q.push_back({3'b010, 8'h61});
      bad = 0;
      while (!tx_busy && bad < 20) begin
         tick();
         bad++;
      end
      tick();
      tick();
      check("midrst_busy", {31'b0, tx_busy}, 32'd1);
      rst = 1'b0;
      q1.delete();
      tick();
      check("midrst_grant", {29'b0, grant}, 32'd0);
      check("midrst_ack", {29'b0, ack}, 32'd0);
      check("midrst_tx_start", {31'b0, tx_start}, 32'd0);
      check("midrst_tx_data", {24'b0, tx_data}, 32'd0);
      check("midrst_exp_empty", exp_q.size(), 32'd0);
      rst = 1'b1;
      starts_before = n_starts;
      for (int i = 0; i < 50; i++) tick();
      check("midrst_no_start", n_starts - starts_before, 32'd0);
      q1.push_back({1'b1, 8'h64});
      exp_q.push_back({3'b010, 8'h64});
      wait_idle("after_rst", 200);
      busy_fixed = 0;

      // Owner abandons its packet after one non-last byte; requester 2 is waiting
      q1.push_back({1'b0, 8'h71});
      exp_q.push_back({3'b010, 8'h71});
      wait_grant("stall", 3'b010, 10);
      q2.push_back({1'b1, 8'h72});
`ifdef UART_ARB_TIMEOUT_EN
      exp_q.push_back({3'b100, 8'h72});
      bad = 0;
      while (tmo_seen == 0 && bad < 400) begin
         tick();
         bad++;
      end
      check("tmo_seen", tmo_seen, 32'd1);
      check("tmo_delay", tmo_cyc - last_fall_cyc, 32'd101);
      check("tmo_grant", {29'b0, grant}, 32'd0);
      wait_idle("tmo_next", 200);
      check("tmo_pulse_count", tmo_seen, 32'd1);
`else
      bad = 0;
      for (int i = 0; i < 10000; i++) begin
         tick();
         if (grant != 3'b010) bad++;
      end
      check("hold_forever", bad, 32'd0);
      check("no_timeout_err", tmo_seen, 32'd0);
      check("hold_exp_empty", exp_q.size(), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
